arp_rx: RTL

Receive-side ARP parser. Consumes ARP payload bytes delivered by the MAC RX stage after the Ethernet header is stripped and EtherType 0x0806 is matched. Validates each packet against the local IP address. It then triggers the ARP transmitter (`i_trig_reply`) for requests addressed to us, and publishes the peer's IP/MAC to the ARP TX and MAC TX header stages.

---
 rtl/arp_rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/arp_rx.sv
// rtl/arp_rx.sv - receive-side ARP parser: field capture, target check, peer publish
// Build option: define ARP_RX_STRICT_HDR_EN to also require HTYPE=1, PTYPE=0x0800, HLEN=6, PLEN=4.
module arp_rx #(
    parameter logic [31:0] P_SRC_IP = {8'd192, 8'd168, 8'd10, 8'd1}
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_src_ip,
    input  logic        i_src_ip_valid,
    input  logic [7:0]  i_mac_data,
    input  logic        i_mac_valid,
    input  logic        i_mac_last,
    output logic        o_trig_reply,
    output logic        o_reply_rcvd,
    output logic [31:0] o_peer_ip,
    output logic [47:0] o_peer_mac,
    output logic        o_peer_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

`ifdef ARP_RX_STRICT_HDR_EN
    localparam bit STRICT_HDR = 1'b1;
`else
    localparam bit STRICT_HDR = 1'b0;
`endif

    logic [1:0]  r_state;
    logic [1:0]  nxt_state;
    logic [5:0]  r_cnt;
    logic [5:0]  byte_off;
    logic [31:0] r_local_ip;

    // Captured ARP fields; THA is never consulted so it is not stored.
    logic [15:0] r_htype;
    logic [15:0] r_ptype;
    logic [7:0]  r_hlen;
    logic [7:0]  r_plen;
    logic [15:0] r_oper;
    logic [47:0] r_sha;
    logic [31:0] r_spa;
    logic [31:0] r_tpa;

    logic len_ok;
    logic oper_ok;
    logic tpa_ok;
    logic hdr_ok;
    logic accept;

    // Offset of the byte on i_mac_data: outside S_RECV a valid byte always starts a new frame.
    always_comb begin
        byte_off = 6'd0;
        if (r_state == S_RECV) begin
            byte_off = r_cnt;
        end
    end

    // Next-state logic; S_CHECK lasts one cycle but may absorb the first byte of the next frame.
    always_comb begin
        nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_mac_valid) begin
                    nxt_state = i_mac_last ? S_CHECK : S_RECV;
                end
            end
            S_RECV: begin
                if (i_mac_valid && i_mac_last) begin
                    nxt_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (i_mac_valid) begin
                    nxt_state = i_mac_last ? S_CHECK : S_RECV;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= nxt_state;
        end
    end

    // Byte counter: restarts at 1 on a frame's first byte, saturates at 63, holds across gaps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 6'd0;
        end else if (i_mac_valid) begin
            if (r_state != S_RECV) begin
                r_cnt <= 6'd1;
            end else if (r_cnt != 6'd63) begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

    // Local IP register; a load in the S_CHECK cycle only affects the following frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_local_ip <= P_SRC_IP;
        end else if (i_src_ip_valid) begin
            r_local_ip <= i_src_ip;
        end
    end

    // Field capture keyed on the byte offset; padding beyond offset 27 falls through.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_htype <= 16'd0;
            r_ptype <= 16'd0;
            r_hlen  <= 8'd0;
            r_plen  <= 8'd0;
            r_oper  <= 16'd0;
            r_sha   <= 48'd0;
            r_spa   <= 32'd0;
            r_tpa   <= 32'd0;
        end else if (i_mac_valid) begin
            case (byte_off)
                6'd0:  r_htype[15:8] <= i_mac_data;
                6'd1:  r_htype[7:0]  <= i_mac_data;
                6'd2:  r_ptype[15:8] <= i_mac_data;
                6'd3:  r_ptype[7:0]  <= i_mac_data;
                6'd4:  r_hlen        <= i_mac_data;
                6'd5:  r_plen        <= i_mac_data;
                6'd6:  r_oper[15:8]  <= i_mac_data;
                6'd7:  r_oper[7:0]   <= i_mac_data;
                6'd8:  r_sha[47:40]  <= i_mac_data;
                6'd9:  r_sha[39:32]  <= i_mac_data;
                6'd10: r_sha[31:24]  <= i_mac_data;
                6'd11: r_sha[23:16]  <= i_mac_data;
                6'd12: r_sha[15:8]   <= i_mac_data;
                6'd13: r_sha[7:0]    <= i_mac_data;
                6'd14: r_spa[31:24]  <= i_mac_data;
                6'd15: r_spa[23:16]  <= i_mac_data;
                6'd16: r_spa[15:8]   <= i_mac_data;
                6'd17: r_spa[7:0]    <= i_mac_data;
                6'd24: r_tpa[31:24]  <= i_mac_data;
                6'd25: r_tpa[23:16]  <= i_mac_data;
                6'd26: r_tpa[15:8]   <= i_mac_data;
                6'd27: r_tpa[7:0]    <= i_mac_data;
                default: ;
            endcase
        end
    end

    // Acceptance terms, meaningful only while in S_CHECK.
    always_comb begin
        len_ok  = (r_cnt >= 6'd28);
        oper_ok = (r_oper == 16'd1) || (r_oper == 16'd2);
        tpa_ok  = (r_tpa == r_local_ip);
        hdr_ok  = !STRICT_HDR ||
                  ((r_htype == 16'h0001) && (r_ptype == 16'h0800) &&
                   (r_hlen == 8'd6) && (r_plen == 8'd4));
        accept  = (r_state == S_CHECK) && len_ok && oper_ok && tpa_ok && hdr_ok;
    end

    // Registered outputs: single-cycle pulses and held peer address on accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_trig_reply <= 1'b0;
            o_reply_rcvd <= 1'b0;
            o_peer_valid <= 1'b0;
            o_peer_ip    <= 32'd0;
            o_peer_mac   <= 48'd0;
        end else begin
            o_trig_reply <= 1'b0;
            o_reply_rcvd <= 1'b0;
            o_peer_valid <= 1'b0;
            if (accept) begin
                o_peer_valid <= 1'b1;
                o_peer_ip    <= r_spa;
                o_peer_mac   <= r_sha;
                o_trig_reply <= (r_oper == 16'd1);
                o_reply_rcvd <= (r_oper == 16'd2);
            end
        end
    end

endmodule
